// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD word decoder: digit widths, the
// one-hot decimal vector type and the emitter FSM states.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam int DEC_W = 10;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [DEC_W-1:0] dec_onehot_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } bcd_dec_state_e;

  // Nibbles 10..15 are not decimal digits.
  function automatic logic bcd_is_invalid(input logic [BCD_W-1:0] nibble);
    return nibble > BCD_MAX;
  endfunction

  // Digit-index width; a single-digit word still gets a 1-bit index.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/bcd_word_decoder_if.sv
// Word-in / digit-out handshake bundle. The decoder uses the slave view,
// the producer/consumer side uses the master view.
interface bcd_word_decoder_if #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = bcd_pkg::idx_width(DIGITS)
) ();

  logic                           in_valid;
  logic                           in_ready;
  logic [bcd_pkg::BCD_W*DIGITS-1:0] in_bcd;

  logic                           out_valid;
  logic                           out_ready;
  bcd_pkg::dec_onehot_t           out_d;
  logic [IDX_W-1:0]               out_idx;
  logic                           out_last;
  logic                           out_err;
  logic                           err_seen;

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_d, out_idx, out_last, out_err, err_seen
  );

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_d, out_idx, out_last, out_err, err_seen
  );

endinterface

// File: rtl/bcd_to_onehot.sv
// Combinational decode of one BCD nibble into a 10-line one-hot vector plus
// an invalid-digit flag; invalid nibbles drive no line at all.
module bcd_to_onehot
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] nibble_i,
  output dec_onehot_t      onehot_o,
  output logic             err_o
);

  // NOTE: every output of a combinational block gets a default before any
  // branch, otherwise an unassigned path infers a latch.
  always_comb begin
    onehot_o = '0;
    err_o    = bcd_is_invalid(nibble_i);
    case (nibble_i)
      4'd0:    onehot_o = 10'b00_0000_0001;
      4'd1:    onehot_o = 10'b00_0000_0010;
      4'd2:    onehot_o = 10'b00_0000_0100;
      4'd3:    onehot_o = 10'b00_0000_1000;
      4'd4:    onehot_o = 10'b00_0001_0000;
      4'd5:    onehot_o = 10'b00_0010_0000;
      4'd6:    onehot_o = 10'b00_0100_0000;
      4'd7:    onehot_o = 10'b00_1000_0000;
      4'd8:    onehot_o = 10'b01_0000_0000;
      4'd9:    onehot_o = 10'b10_0000_0000;
      default: onehot_o = '0;
    endcase
  end

endmodule

// File: rtl/bcd_word_decoder.sv
// Serialises a packed BCD word into one one-hot decimal digit per beat,
// least-significant digit first, with a sticky per-word invalid-digit flag.
module bcd_word_decoder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int IDX_W  = idx_width(DIGITS)
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_word_decoder_if.slave  bus
);

  localparam int               WORD_W   = BCD_W * DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  bcd_dec_state_e    state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_seen_q, err_seen_d;

  dec_onehot_t       nib_onehot;
  logic              nib_err;
  logic              emit;
  logic              is_last;
  logic              out_fire;
  logic              in_ready;
  logic              in_fire;

  bcd_to_onehot u_decode (
    .nibble_i (shift_q[BCD_W-1:0]),
    .onehot_o (nib_onehot),
    .err_o    (nib_err)
  );

  assign emit     = (state_q == EMIT);
  assign is_last  = emit && (idx_q == LAST_IDX);
  assign out_fire = emit && bus.out_ready;
  // The last-digit handshake frees the shift register in the same cycle,
  // so a waiting word is taken without a bubble.
  assign in_ready = !emit || (out_fire && is_last);
  assign in_fire  = bus.in_valid && in_ready;

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire) state_d = EMIT;
      EMIT:    if (out_fire && is_last && !in_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = emit;
    bus.out_d     = emit ? nib_onehot : '0;
    bus.out_idx   = emit ? idx_q : '0;
    bus.out_last  = is_last;
    bus.out_err   = emit && nib_err;
    bus.err_seen  = err_seen_q;
  end

  // Word acceptance overrides the shift: it also wins over an error flagged
  // on the last digit of the outgoing word.
  always_comb begin
    shift_d    = shift_q;
    idx_d      = idx_q;
    err_seen_d = err_seen_q;
    if (out_fire) begin
      if (nib_err) err_seen_d = 1'b1;
      if (!is_last) begin
        shift_d = shift_q >> BCD_W;
        idx_d   = idx_q + IDX_W'(1);
      end
    end
    if (in_fire) begin
      shift_d    = bus.in_bcd;
      idx_d      = '0;
      err_seen_d = 1'b0;
    end
  end

  // NOTE: the shift register is a plain datapath register, not a memory
  // array, so it is reset along with the control state; that keeps a
  // discarded word from ever reaching the decoder after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      idx_q      <= '0;
      err_seen_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      err_seen_q <= err_seen_d;
    end
  end

endmodule

// File: tb/tb_bcd_word_decoder.sv
// Directed bench for bcd_word_decoder: a 4-digit instance for the word tests
// and a 1-digit instance for the single-digit corner.
module tb_bcd_word_decoder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bcd_word_decoder_if #(.DIGITS(4)) bus4 ();
  bcd_word_decoder_if #(.DIGITS(1)) bus1 ();

  bcd_word_decoder #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  bcd_word_decoder #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check the digit presented by the 4-digit instance, then move one cycle on.
  task automatic beat4(input string tag, input int idx, input logic [9:0] d,
                       input logic last, input logic err, input logic seen);
    check({tag, "_valid"}, 32'(bus4.out_valid), 32'd1);
    check({tag, "_d"},     32'(bus4.out_d),     32'(d));
    check({tag, "_idx"},   32'(bus4.out_idx),   32'(idx));
    check({tag, "_last"},  32'(bus4.out_last),  32'(last));
    check({tag, "_err"},   32'(bus4.out_err),   32'(err));
    check({tag, "_seen"},  32'(bus4.err_seen),  32'(seen));
    @(negedge clk);
  endtask

  // Present a word to the idle 4-digit instance for exactly one cycle.
  task automatic send4(input logic [15:0] w);
    bus4.in_valid = 1'b1;
    bus4.in_bcd   = w;
    #1 check("send_in_ready", 32'(bus4.in_ready), 32'd1);
    @(negedge clk);
    bus4.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n          = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_bcd    = '0;
    bus4.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_bcd    = '0;
    bus1.out_ready = 1'b1;

    #2;
    check("rst_valid",    32'(bus4.out_valid), 32'd0);
    check("rst_d",        32'(bus4.out_d),     32'd0);
    check("rst_idx",      32'(bus4.out_idx),   32'd0);
    check("rst_last",     32'(bus4.out_last),  32'd0);
    check("rst_err",      32'(bus4.out_err),   32'd0);
    check("rst_seen",     32'(bus4.err_seen),  32'd0);
    check("rst_in_ready", 32'(bus4.in_ready),  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1234: digits 4,3,2,1
    send4(16'h1234);
    beat4("w1234_0", 0, 10'b0000010000, 1'b0, 1'b0, 1'b0);
    beat4("w1234_1", 1, 10'b0000001000, 1'b0, 1'b0, 1'b0);
    beat4("w1234_2", 2, 10'b0000000100, 1'b0, 1'b0, 1'b0);
    beat4("w1234_3", 3, 10'b0000000010, 1'b1, 1'b0, 1'b0);
    check("w1234_idle_valid", 32'(bus4.out_valid), 32'd0);
    check("w1234_idle_seen",  32'(bus4.err_seen),  32'd0);

    // 9A05: digits 5,0,A(invalid),9; sticky flag rises after the idx2 beat
    send4(16'h9A05);
    beat4("w9a05_0", 0, 10'b0000100000, 1'b0, 1'b0, 1'b0);
    beat4("w9a05_1", 1, 10'b0000000001, 1'b0, 1'b0, 1'b0);
    beat4("w9a05_2", 2, 10'b0000000000, 1'b0, 1'b1, 1'b0);
    beat4("w9a05_3", 3, 10'b1000000000, 1'b1, 1'b0, 1'b1);
    check("w9a05_idle_seen", 32'(bus4.err_seen), 32'd1);
    send4(16'h0000);
    beat4("w0000_0", 0, 10'b0000000001, 1'b0, 1'b0, 1'b0);
    beat4("w0000_1", 1, 10'b0000000001, 1'b0, 1'b0, 1'b0);
    beat4("w0000_2", 2, 10'b0000000001, 1'b0, 1'b0, 1'b0);
    beat4("w0000_3", 3, 10'b0000000001, 1'b1, 1'b0, 1'b0);

    // Back-to-back: 0009 then 8000 with in_valid held, eight beats, no gap
    bus4.in_valid = 1'b1;
    bus4.in_bcd   = 16'h0009;
    @(negedge clk);
    bus4.in_bcd   = 16'h8000;
    #1 check("b2b_in_ready_mid", 32'(bus4.in_ready), 32'd0);
    beat4("b2b_a0", 0, 10'b1000000000, 1'b0, 1'b0, 1'b0);
    beat4("b2b_a1", 1, 10'b0000000001, 1'b0, 1'b0, 1'b0);
    beat4("b2b_a2", 2, 10'b0000000001, 1'b0, 1'b0, 1'b0);
    #1 check("b2b_in_ready_last", 32'(bus4.in_ready), 32'd1);
    beat4("b2b_a3", 3, 10'b0000000001, 1'b1, 1'b0, 1'b0);
    bus4.in_valid = 1'b0;
    beat4("b2b_b0", 0, 10'b0000000001, 1'b0, 1'b0, 1'b0);
    beat4("b2b_b1", 1, 10'b0000000001, 1'b0, 1'b0, 1'b0);
    beat4("b2b_b2", 2, 10'b0000000001, 1'b0, 1'b0, 1'b0);
    beat4("b2b_b3", 3, 10'b0100000000, 1'b1, 1'b0, 1'b0);
    check("b2b_idle_valid", 32'(bus4.out_valid), 32'd0);

    // Stall five cycles on idx1 of 5678 while a new word waits upstream
    send4(16'h5678);
    beat4("stall_0", 0, 10'b0100000000, 1'b0, 1'b0, 1'b0);
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.in_bcd    = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid",    32'(bus4.out_valid), 32'd1);
      check("stall_d",        32'(bus4.out_d),     32'(10'b0010000000));
      check("stall_idx",      32'(bus4.out_idx),   32'd1);
      check("stall_in_ready", 32'(bus4.in_ready),  32'd0);
      @(negedge clk);
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    beat4("stall_1", 1, 10'b0010000000, 1'b0, 1'b0, 1'b0);
    beat4("stall_2", 2, 10'b0001000000, 1'b0, 1'b0, 1'b0);
    beat4("stall_3", 3, 10'b0000100000, 1'b1, 1'b0, 1'b0);
    check("stall_idle_valid", 32'(bus4.out_valid), 32'd0);

    // Reset in the middle of 4321, then a fresh word starts at idx0
    send4(16'h4321);
    beat4("rstw_0", 0, 10'b0000000010, 1'b0, 1'b0, 1'b0);
    beat4("rstw_1", 1, 10'b0000000100, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid",    32'(bus4.out_valid), 32'd0);
    check("midrst_d",        32'(bus4.out_d),     32'd0);
    check("midrst_idx",      32'(bus4.out_idx),   32'd0);
    check("midrst_last",     32'(bus4.out_last),  32'd0);
    check("midrst_err",      32'(bus4.out_err),   32'd0);
    check("midrst_in_ready", 32'(bus4.in_ready),  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("postrst_valid", 32'(bus4.out_valid), 32'd0);
    @(negedge clk);
    send4(16'h0001);
    beat4("postrst_0", 0, 10'b0000000010, 1'b0, 1'b0, 1'b0);
    beat4("postrst_1", 1, 10'b0000000001, 1'b0, 1'b0, 1'b0);
    beat4("postrst_2", 2, 10'b0000000001, 1'b0, 1'b0, 1'b0);
    beat4("postrst_3", 3, 10'b0000000001, 1'b1, 1'b0, 1'b0);

    // Single-digit instance: invalid F, then a valid 3
    bus1.in_valid = 1'b1;
    bus1.in_bcd   = 4'hF;
    #1 check("d1_in_ready", 32'(bus1.in_ready), 32'd1);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    check("d1f_valid", 32'(bus1.out_valid), 32'd1);
    check("d1f_d",     32'(bus1.out_d),     32'd0);
    check("d1f_err",   32'(bus1.out_err),   32'd1);
    check("d1f_last",  32'(bus1.out_last),  32'd1);
    check("d1f_idx",   32'(bus1.out_idx),   32'd0);
    @(negedge clk);
    check("d1f_idle_valid", 32'(bus1.out_valid), 32'd0);
    check("d1f_idle_seen",  32'(bus1.err_seen),  32'd1);
    bus1.in_valid = 1'b1;
    bus1.in_bcd   = 4'h3;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    check("d1_3_d",    32'(bus1.out_d),    32'(10'b0000001000));
    check("d1_3_err",  32'(bus1.out_err),  32'd0);
    check("d1_3_last", 32'(bus1.out_last), 32'd1);
    check("d1_3_seen", 32'(bus1.err_seen), 32'd0);
    @(negedge clk);
    check("d1_3_idle_valid", 32'(bus1.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_word_decoder.md
# bcd_word_decoder

- Takes a packed multi-digit BCD word over a valid/ready handshake.
- Emits the digits one per beat, least-significant digit first, each as a 10-bit one-hot decimal line vector (bit i high = digit i).
- Flags any nibble above 9 as invalid.
- It is the decoding counterpart of the decimal-to-binary encoder, and sits between the numeric datapath and the per-digit one-hot consumers (display/lamp drivers).

## Interface
- `DIGITS`, default 4: number of BCD digits per input word; legal range is 1..16.
- `IDX_W`, default `$clog2(DIGITS)` (minimum 1): width of the digit index.
- `clk` input 1: single clock; all flops are rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: block can accept a word.
- `in_bcd` input `4*DIGITS`: packed BCD; digit k is `in_bcd[4k+3:4k]`.
- `out_valid` output 1: `out_d`, `out_idx`, `out_last` and `out_err` are valid.
- `out_ready` input 1: downstream accepts the current digit.
- `out_d` output 10: one-hot decimal; `out_d[i]=1` when the digit equals i; all zeros when the digit is invalid.
- `out_idx` output `IDX_W`: index k of the digit presented.
- `out_last` output 1: presented digit is `DIGITS-1`.
- `out_err` output 1: presented nibble is 10..15.
- `err_seen` output 1: sticky; set when any digit of the current word is invalid; cleared when a new word is accepted.

## Operation
- Two-state FSM, `IDLE` and `EMIT`.
- In `IDLE`:
  - `in_ready=1` and `out_valid=0`.
  - On `in_valid&&in_ready`, register `in_bcd` into the shift register, set `idx=0`, clear `err_seen`, and go to `EMIT`.
- In `EMIT`:
  - `out_valid=1`.
  - The presented digit is the low nibble of the shift register.
  - `out_d`, `out_err` and `out_last` are decoded combinationally from registered state only, so they hold stable while stalled.
- On `out_valid&&out_ready`:
  - If `out_err`, set `err_seen`.
  - If not `out_last`: shift right by 4, increment `idx`, stay in `EMIT`.
  - If `out_last`: return to `IDLE`, except when `in_valid` is high in the same cycle (see back-to-back).
- Back-to-back: `in_ready = (state==IDLE) | (out_valid & out_ready & out_last)`.
  - A word accepted on the last-digit handshake reloads the shift register, sets `idx=0`, clears `err_seen` (the new word's first digit may set it again only on its own handshake), and the FSM stays in `EMIT`. No bubble between words.
- Stall: while `out_valid && !out_ready`, all outputs and state hold; upstream sees `in_ready=0`.
- Invalid nibble (10..15): `out_d=10'b0` and `out_err=1`. The digit is still emitted and consumes one beat. Processing does not abort.
- `DIGITS=1`: `out_last` is always 1 in `EMIT`; `out_idx` is constant 0.
- Reset (any time, including mid-word):
  - state=`IDLE`, `out_valid=0`, `out_d=0`, `out_idx=0`, `out_last=0`, `out_err=0`, `err_seen=0`, shift register cleared.
  - Any partially emitted word is discarded.
  - `in_ready` reads 1 once in `IDLE`. Transfers while `rst_n` is low are ignored, and upstream must not count them.

## Timing
- Input acceptance at edge N gives `out_valid` from edge N (visible in cycle N+1), with digit 0 presented.
- Throughput is one digit per cycle with `out_ready` held high. A word takes exactly `DIGITS` cycles. Sustained rate is one word per `DIGITS` cycles.
- `in_ready` and the last-beat path are combinational from `out_ready` and `out_valid`. No other input-to-output combinational path exists.
- `err_seen` is updated at the edge of the handshake of the offending digit.
- Reset assertion takes effect immediately (asynchronous). Deassertion is assumed synchronised externally to `clk`.

## Structure
- Shared package `bcd_pkg`:
  - `BCD_W=4`, `DEC_W=10`, `BCD_MAX=4'd9`.
  - typedef `dec_onehot_t` (logic [9:0]).
  - FSM state enum `bcd_dec_state_e` {`IDLE`, `EMIT`}.
- One sub-module, `bcd_to_onehot`: purely combinational 4-bit-to-`{onehot[9:0], err}` decode, instanced once on the shift-register low nibble.
- Top holds the FSM, shift register, index counter and sticky flag.

## Test plan
- `DIGITS=4`, `in_bcd=16'h1234`, `out_ready=1` → four beats:
  - idx0 `out_d=10'b0000010000` (4)
  - idx1 `0000001000` (3)
  - idx2 `0000000100` (2)
  - idx3 `0000000010` (1) with `out_last=1`
  - then `out_valid=0`, `err_seen=0`.
- `in_bcd=16'h9A05` → beats 5, 0, err (`out_d=0`, `out_err=1`), 9. `err_seen` rises after beat idx2. The next word `16'h0000` clears `err_seen` on acceptance.
- Two words presented with `in_valid` held (`16'h0009` then `16'h8000`) → eight consecutive beats with no gap. The second word is accepted on the idx3 handshake of the first.
- `out_ready` low for 5 cycles at idx1 of `16'h5678` → `out_d=10'b0010000000` (7), `out_idx=1`, `in_ready=0` all held. Resuming completes 6, 5.
- `rst_n` pulsed low during idx2 of `16'h4321` → all outputs 0 immediately. After release, `in_ready=1`; the next word starts at idx0.
- `DIGITS=1`, `in_bcd=4'hF` → one beat with `out_err=1`, `out_last=1`, `out_idx=0`.
